memory_access_unit: RTL and testbench

MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

---
 rtl/memory_access_unit_if.sv | 31 +++
 rtl/memory_access_unit.sv | 146 ++++++++++++++
 tb/tb_memory_access_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/memory_access_unit_if.sv
// Word-addressed memory bus between the memory access unit (master) and the memory system (slave).
// A transfer is held on the bus while bus_req is high and completes in the cycle bus_ack is high.
interface memory_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_be,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_be,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );
endinterface

// File: rtl/memory_access_unit.sv
// Memory-stage load/store unit: stalls the pipeline while one bus access is outstanding, with wait timeout.
// Optional feature macro MAU_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of issuing them.
module memory_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        MemReadM,
    input  logic                        MemWriteM,
    input  logic [1:0]                  SizeM,
    input  logic [31:0]                 ALUResultM,
    input  logic [31:0]                 WriteDataM,
    output logic [31:0]                 ReadDataM,
    output logic                        StallM,
    output logic                        BusErrM,
    output logic                        MisalignM,
    memory_access_unit_if.master        bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int            CW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [CW-1:0] wait_q;
    logic        err_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        we_q;

    logic access;
    logic misaligned;
    logic latch;
    logic stall_c;
    logic misalign_c;
    logic timeout;
    logic rd_ack;

    assign access = MemReadM | MemWriteM;

`ifdef MAU_MISALIGN_TRAP_EN
    assign misaligned = ((SizeM == 2'b01) & ALUResultM[0]) | (SizeM[1] & (|ALUResultM[1:0]));
`else
    assign misaligned = 1'b0;
`endif

    assign timeout = (state_q == REQ) & ~bus.bus_ack & (wait_q == LAST_WAIT);
    assign rd_ack  = (state_q == REQ) & bus.bus_ack & ~we_q;

    // NOTE: every always_comb output gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        stall_c    = 1'b0;
        misalign_c = 1'b0;
        latch      = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        misalign_c = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        latch   = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                stall_c = 1'b1;
                if (bus.bus_ack || timeout) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the IDLE-state outputs are combinational from the pipeline inputs, so they are also
    // gated by reset to drop the instant reset asserts, not just after the state register clears.
    assign StallM    = stall_c & reset;
    assign MisalignM = misalign_c & reset;
    assign BusErrM   = err_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            err_q     <= 1'b0;
            we_q      <= 1'b0;
            ReadDataM <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= timeout;
            if (latch) begin
                wait_q <= '0;
                we_q   <= MemWriteM;
            end else if ((state_q == REQ) && !bus.bus_ack) begin
                wait_q <= wait_q + 1'b1;
            end
            if (rd_ack) begin
                ReadDataM <= bus.bus_rdata;
            end else if (timeout) begin
                ReadDataM <= '0;
            end
        end
    end

    // NOTE: address/data/size are pure datapath, only looked at while bus_req is high, so no reset.
    always_ff @(posedge clk) begin
        if (latch) begin
            addr_q  <= ALUResultM;
            wdata_q <= WriteDataM;
            size_q  <= SizeM;
        end
    end

    always_comb begin
        bus.bus_be    = 4'b1111;
        bus.bus_wdata = wdata_q;
        case (size_q)
            2'b00: begin
                bus.bus_be    = 4'b0001 << addr_q[1:0];
                bus.bus_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                bus.bus_be    = 4'b0011 << {addr_q[1], 1'b0};
                bus.bus_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                bus.bus_be    = 4'b1111;
                bus.bus_wdata = wdata_q;
            end
        endcase
    end

    assign bus.bus_req  = (state_q == REQ);
    assign bus.bus_we   = (state_q == REQ) & we_q;
    assign bus.bus_addr = {addr_q[31:2], 2'b00};

endmodule

// File: tb/tb_memory_access_unit.sv
// Self-checking bench for memory_access_unit: vector table with a scoreboard queue, plus reset and
// ack-while-idle sequences. Expectations follow the MAU_MISALIGN_TRAP_EN setting of the build.
module tb_memory_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM;
    logic [1:0]  SizeM;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM, BusErrM, MisalignM;

    memory_access_unit_if bus ();

    memory_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .SizeM      (SizeM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .BusErrM    (BusErrM),
        .MisalignM  (MisalignM),
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          ack_wait;   // REQ cycle index that gets bus_ack; -1 never acks
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_we;
        int          e_stall;
        logic [31:0] e_rd;
        logic        e_err;
        logic        e_mis;
    } vec_t;

    vec_t vecs[12];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", what, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic rd, input logic wr, input logic [1:0] sz,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                                input int aw, input logic [31:0] ea, input logic [3:0] ebe,
                                input logic [31:0] ewd, input logic ewe, input int est,
                                input logic [31:0] erd, input logic eerr, input logic emis);
        vec_t v;
        v.name = nm; v.rd = rd; v.wr = wr; v.size = sz; v.addr = a; v.wd = wd; v.rdata = rdat;
        v.ack_wait = aw; v.e_addr = ea; v.e_be = ebe; v.e_wdata = ewd; v.e_we = ewe;
        v.e_stall = est; v.e_rd = erd; v.e_err = eerr; v.e_mis = emis;
        return v;
    endfunction

    task automatic run_access(input vec_t v);
        vec_t e;
        int   ncyc;
        int   nreq;
        @(negedge clk);
        MemReadM = v.rd; MemWriteM = v.wr; SizeM = v.size;
        ALUResultM = v.addr; WriteDataM = v.wd;
        bus.bus_ack = 1'b0; bus.bus_rdata = v.rdata;
        sb.push_back(v);
        ncyc = 0;
        nreq = 0;
        forever begin
            #1;
            if (!StallM || ncyc >= 200) break;
            ncyc++;
            if (bus.bus_req) begin
                if (nreq == 0) begin
                    check({v.name, " bus_addr"}, bus.bus_addr, v.e_addr);
                    check({v.name, " bus_be"}, 32'(bus.bus_be), 32'(v.e_be));
                    check({v.name, " bus_wdata"}, bus.bus_wdata, v.e_wdata);
                    check({v.name, " bus_we"}, 32'(bus.bus_we), 32'(v.e_we));
                end
                bus.bus_ack = (nreq == v.ack_wait);
                nreq++;
            end else begin
                bus.bus_ack = 1'b0;
            end
            @(negedge clk);
        end
        e = sb.pop_front();
        check({e.name, " stall cycles"}, ncyc, e.e_stall);
        check({e.name, " req cycles"}, nreq, e.e_mis ? 0 : e.e_stall - 1);
        check({e.name, " ReadDataM"}, ReadDataM, e.e_rd);
        check({e.name, " BusErrM"}, 32'(BusErrM), 32'(e.e_err));
        check({e.name, " MisalignM"}, 32'(MisalignM), 32'(e.e_mis));
        // inputs were held through the final cycle; the following cycle must be quiet
        MemReadM = 1'b0; MemWriteM = 1'b0; bus.bus_ack = 1'b0;
        @(negedge clk);
        #1;
        check({e.name, " next StallM"}, 32'(StallM), 32'h0);
        check({e.name, " next BusErrM"}, 32'(BusErrM), 32'h0);
        check({e.name, " next MisalignM"}, 32'(MisalignM), 32'h0);
        check({e.name, " next bus_req"}, 32'(bus.bus_req), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            name        rd wr size  addr         wd           rdata        aw  e_addr       be       e_wdata      we st e_rd         er mis
        vecs[0]  = mk("lw100",    1, 0, 2'b10, 32'h100,    32'h0,       32'hCAFEBABE, 0, 32'h100,    4'b1111, 32'h0,       0, 2, 32'hCAFEBABE, 0, 0);
        vecs[1]  = mk("sb203",    0, 1, 2'b00, 32'h203,    32'hA5,      32'h0,        3, 32'h200,    4'b1000, 32'hA5A5A5A5, 1, 5, 32'hCAFEBABE, 0, 0);
        vecs[2]  = mk("sh012",    0, 1, 2'b01, 32'h012,    32'h1234BEEF, 32'h0,       1, 32'h010,    4'b1100, 32'hBEEFBEEF, 1, 3, 32'hCAFEBABE, 0, 0);
        vecs[3]  = mk("lh300",    1, 0, 2'b01, 32'h300,    32'h0,       32'h11223344, 0, 32'h300,    4'b0011, 32'h0,       0, 2, 32'h11223344, 0, 0);
        vecs[4]  = mk("lb401",    1, 0, 2'b00, 32'h401,    32'h0,       32'h55667788, 2, 32'h400,    4'b0010, 32'h0,       0, 4, 32'h55667788, 0, 0);
        vecs[5]  = mk("sz11",     0, 1, 2'b11, 32'h500,    32'hDEADBEEF, 32'h0,       0, 32'h500,    4'b1111, 32'hDEADBEEF, 1, 2, 32'h55667788, 0, 0);
        vecs[6]  = mk("rdwr600",  1, 1, 2'b10, 32'h600,    32'h0BADF00D, 32'hFFFFFFFF, 0, 32'h600,   4'b1111, 32'h0BADF00D, 1, 2, 32'h55667788, 0, 0);
        vecs[7]  = mk("lw_tmo",   1, 0, 2'b10, 32'h700,    32'h0,       32'h99999999, -1, 32'h700,   4'b1111, 32'h0,       0, 5, 32'h0,        1, 0);
        vecs[8]  = mk("lb002",    1, 0, 2'b00, 32'h002,    32'h0,       32'h000000AB, 0, 32'h000,    4'b0100, 32'h0,       0, 2, 32'h000000AB, 0, 0);
`ifdef MAU_MISALIGN_TRAP_EN
        vecs[9]  = mk("lw102",    1, 0, 2'b10, 32'h102,    32'h0,       32'h13572468, 0, 32'h100,    4'b1111, 32'h0,       0, 0, 32'h000000AB, 0, 1);
        vecs[10] = mk("sh013",    0, 1, 2'b01, 32'h013,    32'hCDEF,    32'h0,        0, 32'h010,    4'b1100, 32'hCDEFCDEF, 1, 0, 32'h000000AB, 0, 1);
`else
        vecs[9]  = mk("lw102",    1, 0, 2'b10, 32'h102,    32'h0,       32'h13572468, 0, 32'h100,    4'b1111, 32'h0,       0, 2, 32'h13572468, 0, 0);
        vecs[10] = mk("sh013",    0, 1, 2'b01, 32'h013,    32'hCDEF,    32'h0,        0, 32'h010,    4'b1100, 32'hCDEFCDEF, 1, 2, 32'h13572468, 0, 0);
`endif
        vecs[11] = mk("sb_tmo",   0, 1, 2'b00, 32'h800,    32'h77,      32'h0,       -1, 32'h800,    4'b0001, 32'h77777777, 1, 5, 32'h0,        1, 0);

        // reset asserted with a load pending on the inputs: nothing may leak out
        reset = 1'b1;
        MemReadM = 1'b1; MemWriteM = 1'b0; SizeM = 2'b10;
        ALUResultM = 32'h100; WriteDataM = 32'h0;
        bus.bus_ack = 1'b0; bus.bus_rdata = 32'h0;
        #3 reset = 1'b0;
        #1;
        check("reset StallM", 32'(StallM), 32'h0);
        check("reset bus_req", 32'(bus.bus_req), 32'h0);
        check("reset bus_we", 32'(bus.bus_we), 32'h0);
        check("reset BusErrM", 32'(BusErrM), 32'h0);
        check("reset MisalignM", 32'(MisalignM), 32'h0);
        check("reset ReadDataM", ReadDataM, 32'h0);
        MemReadM = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) run_access(vecs[i]);

        // bus_ack while idle must not disturb anything
        @(negedge clk);
        bus.bus_rdata = 32'h12345678;
        bus.bus_ack = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("idle ack ReadDataM", ReadDataM, 32'h0);
        check("idle ack StallM", 32'(StallM), 32'h0);
        check("idle ack bus_req", 32'(bus.bus_req), 32'h0);
        bus.bus_ack = 1'b0;

        run_access(mk("lwA00", 1, 0, 2'b10, 32'hA00, 32'h0, 32'h600DF00D, 0, 32'hA00, 4'b1111, 32'h0, 0, 2, 32'h600DF00D, 0, 0));

        // reset in the second REQ cycle, with the load still on the inputs
        @(negedge clk);
        MemReadM = 1'b1; MemWriteM = 1'b0; SizeM = 2'b10; ALUResultM = 32'h900;
        bus.bus_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("pre-reset bus_req", 32'(bus.bus_req), 32'h1);
        reset = 1'b0;
        #1;
        check("mid-REQ reset bus_req", 32'(bus.bus_req), 32'h0);
        check("mid-REQ reset StallM", 32'(StallM), 32'h0);
        check("mid-REQ reset ReadDataM", ReadDataM, 32'h0);
        MemReadM = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        run_access(mk("lw904", 1, 0, 2'b10, 32'h904, 32'h0, 32'h0BADCAFE, 0, 32'h904, 4'b1111, 32'h0, 0, 2, 32'h0BADCAFE, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
